// File: rtl/id_match_stats_if.sv
// id_match_stats_if: match/clear/pop inputs and statistics outputs of the identifier match-run tracker
interface id_match_stats_if #(
  parameter int CNT_W = 16,
  parameter int LEN_W = 8
);
  logic             match;
  logic             clr;
  logic             pop;
  logic [CNT_W-1:0] token_cnt;
  logic [LEN_W-1:0] cur_len;
  logic [LEN_W-1:0] max_len;
  logic             done;
  logic [LEN_W-1:0] len_out;
  logic             len_valid;
  logic             overflow;
  modport master (
    output match, clr, pop,
    input  token_cnt, cur_len, max_len, done, len_out, len_valid, overflow
  );
  modport slave (
    input  match, clr, pop,
    output token_cnt, cur_len, max_len, done, len_out, len_valid, overflow
  );
endinterface

// File: rtl/id_match_stats.sv
// id_match_stats: counts match runs, tracks current/longest run length and queues completed lengths in a FIFO
module id_match_stats #(
  parameter int CNT_W = 16,
  parameter int LEN_W = 8,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset_n,
  id_match_stats_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  logic             match_d, skip, done_q, ovf_q;
  logic [CNT_W-1:0] tok_q;
  logic [LEN_W-1:0] cur_q, max_q;
  logic [LEN_W-1:0] mem [DEPTH];
  logic [PW-1:0]    rd, wr;
  logic [PW:0]      cnt;
  logic             rise, cont, fall, push, pop_ok, full, push_ok;
  always_comb begin
    rise    = bus.match & ~match_d;
    cont    = bus.match & match_d;
    fall    = ~bus.match & match_d;
    push    = fall & ~skip;
    pop_ok  = bus.pop & (cnt != '0);
    full    = cnt == (PW+1)'(DEPTH);
    push_ok = push & (~full | pop_ok);
  end
  assign bus.token_cnt = tok_q;
  assign bus.cur_len   = cur_q;
  assign bus.max_len   = max_q;
  assign bus.done      = done_q;
  assign bus.overflow  = ovf_q;
  assign bus.len_valid = cnt != '0;
  assign bus.len_out   = (cnt != '0) ? mem[rd] : '0;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      match_d <= 1'b0;
      skip    <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      tok_q   <= '0;
      cur_q   <= '0;
      max_q   <= '0;
      rd      <= '0;
      wr      <= '0;
      cnt     <= '0;
    end else begin
      match_d <= bus.match;
      if (bus.clr) begin
        // a run straddling clr keeps counting length but is never reported
        skip   <= bus.match;
        done_q <= 1'b0;
        ovf_q  <= 1'b0;
        tok_q  <= '0;
        cur_q  <= '0;
        max_q  <= '0;
        rd     <= '0;
        wr     <= '0;
        cnt    <= '0;
      end else begin
        done_q <= push;
        cur_q  <= rise ? LEN_W'(1) : cont ? ((cur_q == '1) ? cur_q : cur_q + 1'b1) : '0;
        if (rise && tok_q != '1) tok_q <= tok_q + 1'b1;
        if (fall) skip <= 1'b0;
        if (push && cur_q > max_q) max_q <= cur_q;
        if (push && !push_ok) ovf_q <= 1'b1;
        if (push_ok) begin
          mem[wr] <= cur_q;
          wr      <= wr + 1'b1;
        end
        if (pop_ok) rd <= rd + 1'b1;
        cnt <= cnt + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop_ok};
      end
    end
  end
endmodule

// File: doc/id_match_stats.md
Name: id_match_stats

Overview:
- Downstream consumer of the identifier-recognising FSM's registered `out` flag; one input sample per clock, no valid qualifier.
- Detects each identifier match run: a maximal interval where `match` is high, i.e. the trailing digit run of a letter+digit identifier.
- Keeps a saturating token count, the current and longest run lengths, and a small FIFO of completed run lengths drained by a valid/ready consumer.

Parameters:
- CNT_W, 16, width of token counter.
- LEN_W, 8, width of run-length values.
- DEPTH, 4, FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock, all logic on posedge.
- reset_n  in  1  synchronous active-low reset.
- match  in  1  FSM match flag, sampled every cycle.
- clr  in  1  synchronous statistics/FIFO clear, active-high.
- pop  in  1  consumer ready; dequeues head when len_valid=1.
- token_cnt  out  CNT_W  number of runs started.
- cur_len  out  LEN_W  length of run in progress (0 when idle).
- max_len  out  LEN_W  longest completed run.
- done  out  1  one-cycle pulse: a run completed.
- len_out  out  LEN_W  FIFO head (completed run length).
- len_valid  out  1  FIFO non-empty.
- overflow  out  1  sticky: a completed run was dropped because the FIFO was full.

Behaviour:
- Reset (reset_n=0 at posedge): all outputs 0, FIFO empty, match_d=0, skip=0. Reset overrides clr and everything else.
- match_d <= match every non-reset cycle, including clr cycles.
- Rise (match=1, match_d=0): token_cnt+1 (saturates at 2^CNT_W-1); cur_len<=1.
- Continue (match=1, match_d=1): cur_len+1, saturating at 2^LEN_W-1; it never wraps.
- Fall (match=0, match_d=1):
  - done<=1 in the next cycle.
  - cur_len pushed to FIFO; cur_len<=0.
  - max_len<=max(max_len, cur_len).
  - done is 0 in every cycle without a fall.
- Latency: done, and len_valid when the FIFO was empty, rise the cycle after the edge that samples the falling match. There is no bypass.
- FIFO:
  - Circular buffer with rd/wr pointers plus count. len_out = entry at rd pointer. len_out is 0 when empty.
  - Pop is effective only when pop=1 and len_valid=1; pop on an empty FIFO is ignored.
  - Push while full with no effective pop: the entry is dropped and overflow<=1 (sticky until clr/reset). token_cnt and max_len still update.
  - Push and effective pop in the same cycle: both happen. Count is unchanged and no overflow occurs, even when full.
  - Pointers wrap modulo DEPTH.
- clr=1 (priority over all non-reset updates):
  - token_cnt, cur_len, max_len, done, overflow <= 0; FIFO emptied; pop ignored.
  - If match=1 in the clr cycle, skip<=1. A run still in progress after clr then:
    - increments cur_len normally;
    - at its fall is not pushed and does not update max_len or done;
    - skip clears and cur_len<=0.
  - A rise on the clr cycle itself is not counted.
- Two back-to-back runs are always separated by at least one match=0 cycle. The block must not rely on this: a fall followed by a rise on consecutive cycles is handled independently.

Test Plan:
- Reset_n=0 for 2 cycles, then match=0 for 3 cycles -> all outputs 0, len_valid=0, done never pulses.
- Match sequence 0,1,1,1,0,0 -> token_cnt=1 after the first high sample. cur_len goes 1,2,3. One done pulse the cycle after the fall; len_out=3, len_valid=1, max_len=3, cur_len=0.
- Runs of length 2,5,1,4,3 with pop=0, DEPTH=4 -> token_cnt=5, max_len=5, FIFO holds 2,5,1,4, overflow=1. Then pop for 4 cycles -> len_out sequence 2,5,1,4, then len_valid=0.
- FIFO full (4 entries), a run falls while pop=1 in the same cycle -> count stays 4, overflow stays 0, new head is the second entry, tail is the new length.
- Match held high 300 cycles (LEN_W=8), then low -> cur_len saturates at 255, pushed length 255, max_len=255.
- Run in progress at length 3, clr=1 for one cycle while match=1, match high 2 more cycles then low -> all stats 0 after clr, no done pulse, nothing pushed. A following run of length 2 -> token_cnt=1, len_out=2.
